// File: rtl/suit_match_pkg.sv
// Shared definitions for the suit kernel matcher.
//   state_t           : scheduler FSM states
//   HEART..SPADE      : kernel ROM bank order
//   score_w / idx_w   : widths of the mismatch score and the kernel index
package suit_match_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    DRAIN   = 3'd2,
    COMPARE = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam int HEART   = 0;
  localparam int DIAMOND = 1;
  localparam int CLUB    = 2;
  localparam int SPADE   = 3;

  // Must hold KSIZE itself (a fully mismatching window).
  function automatic int score_w(input int ksize);
    return $clog2(ksize + 1);
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/suit_kernel_scheduler_latency_tag_pipe.sv
// Valid-tag delay line matching the memory read latency.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_flush        : synchronous clear of every in-flight tag
//   i_vld          : tag entering this cycle
//   o_vld          : tag that entered DEPTH cycles earlier
module latency_tag_pipe #(
  parameter int DEPTH = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_flush,
  input  logic i_vld,
  output logic o_vld
);

  logic [DEPTH-1:0] r_tag;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tag <= '0;
    end else if (i_flush) begin
      r_tag <= '0;
    end else begin
      r_tag[0] <= i_vld;
      for (int i = 1; i < DEPTH; i++) r_tag[i] <= r_tag[i-1];
    end
  end

  assign o_vld = r_tag[DEPTH-1];

endmodule

// File: rtl/suit_kernel_scheduler.sv
// Runs one XOR-match datapath over NUM_KERNELS stored suit kernels for a
// captured corner mask and reports the kernel with the fewest mismatches.
//   clk, rst          : clock, asynchronous active-low reset
//   start, abort      : begin a run / cancel the current run
//   mask_rd_addr      : mask buffer address, data on mask_bit RD_LAT later
//   kernel_rd_addr    : kernel ROM address, data on kernel_bit RD_LAT later
//   busy              : run in progress
//   score_valid/idx   : per-kernel mismatch count pulse
//   done              : run complete; best_idx/best_score/match valid
module suit_kernel_scheduler
  import suit_match_pkg::*;
#(
  parameter int KSIZE        = 812,
  parameter int NUM_KERNELS  = 4,
  parameter int RD_LAT       = 2,
  parameter int MATCH_THRESH = 200,
  localparam int AW  = $clog2(KSIZE),
  localparam int KAW = $clog2(NUM_KERNELS * KSIZE),
  localparam int IW  = idx_w(NUM_KERNELS),
  localparam int SW  = score_w(KSIZE)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           abort,
  output logic [AW-1:0]  mask_rd_addr,
  input  logic           mask_bit,
  output logic [KAW-1:0] kernel_rd_addr,
  input  logic           kernel_bit,
  output logic           busy,
  output logic           score_valid,
  output logic [IW-1:0]  score_idx,
  output logic [SW-1:0]  score,
  output logic           done,
  output logic [IW-1:0]  best_idx,
  output logic [SW-1:0]  best_score,
  output logic           match
);

  localparam int DW = $clog2(RD_LAT + 1);

  state_t          r_state;
  logic [AW-1:0]   r_a;
  logic [IW-1:0]   r_k;
  logic [DW-1:0]   r_drain;
  logic [SW-1:0]   r_acc;
  // Committed result of the last completed run; restored on abort.
  logic [IW-1:0]   r_cm_best_idx;
  logic [SW-1:0]   r_cm_best_score;
  logic            r_cm_match;

  logic            w_tag_out;
  logic            w_flush;
  logic            w_issue;
  logic [SW-1:0]   w_acc_next;
  logic [SW-1:0]   w_best_score_next;
  logic [IW-1:0]   w_best_idx_next;

  assign w_issue = (r_state == ISSUE);
  assign w_flush = abort && (r_state != IDLE);

  latency_tag_pipe #(.DEPTH(RD_LAT)) u_tag_pipe (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_flush (w_flush),
    .i_vld   (w_issue),
    .o_vld   (w_tag_out)
  );

  // Returning tag lines up with the data read for its address; saturate at KSIZE.
  always_comb begin
    w_acc_next = r_acc;
    if (w_tag_out && ((mask_bit ^ kernel_bit) == 1'b1) && (r_acc != SW'(KSIZE)))
      w_acc_next = r_acc + 1'b1;
  end

  // Strict less-than keeps the lower index on a tie.
  always_comb begin
    w_best_score_next = best_score;
    w_best_idx_next   = best_idx;
    if (r_acc < best_score) begin
      w_best_score_next = r_acc;
      w_best_idx_next   = r_k;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state         <= IDLE;
      r_a             <= '0;
      r_k             <= '0;
      r_drain         <= '0;
      r_acc           <= '0;
      r_cm_best_idx   <= '0;
      r_cm_best_score <= '0;
      r_cm_match      <= 1'b0;
      mask_rd_addr    <= '0;
      kernel_rd_addr  <= '0;
      busy            <= 1'b0;
      score_valid     <= 1'b0;
      score_idx       <= '0;
      score           <= '0;
      done            <= 1'b0;
      best_idx        <= '0;
      best_score      <= '0;
      match           <= 1'b0;
    end else begin
      score_valid <= 1'b0;
      done        <= 1'b0;
      if (w_flush) begin
        r_state    <= IDLE;
        busy       <= 1'b0;
        r_acc      <= '0;
        best_idx   <= r_cm_best_idx;
        best_score <= r_cm_best_score;
        match      <= r_cm_match;
      end else begin
        case (r_state)
          IDLE: begin
            if (start && !abort) begin
              r_state        <= ISSUE;
              busy           <= 1'b1;
              r_k            <= '0;
              r_a            <= '0;
              r_acc          <= '0;
              best_score     <= '1;
              best_idx       <= '0;
              match          <= 1'b0;
              mask_rd_addr   <= '0;
              kernel_rd_addr <= '0;
            end
          end
          ISSUE: begin
            r_acc <= w_acc_next;
            if (r_a == AW'(KSIZE - 1)) begin
              r_state <= DRAIN;
              r_drain <= '0;
            end else begin
              r_a            <= r_a + 1'b1;
              mask_rd_addr   <= r_a + 1'b1;
              kernel_rd_addr <= kernel_rd_addr + 1'b1;
            end
          end
          DRAIN: begin
            r_acc <= w_acc_next;
            if (r_drain == DW'(RD_LAT - 1)) begin
              r_state     <= COMPARE;
              score_valid <= 1'b1;
              score       <= w_acc_next;
              score_idx   <= r_k;
            end else begin
              r_drain <= r_drain + 1'b1;
            end
          end
          COMPARE: begin
            best_score <= w_best_score_next;
            best_idx   <= w_best_idx_next;
            r_acc      <= '0;
            r_a        <= '0;
            if (r_k == IW'(NUM_KERNELS - 1)) begin
              r_state <= DONE;
              done    <= 1'b1;
              match   <= (int'(w_best_score_next) <= MATCH_THRESH);
            end else begin
              r_k            <= r_k + 1'b1;
              r_state        <= ISSUE;
              mask_rd_addr   <= '0;
              // Kernels are stored back-to-back, so the next base is one past.
              kernel_rd_addr <= kernel_rd_addr + 1'b1;
            end
          end
          DONE: begin
            r_state         <= IDLE;
            busy            <= 1'b0;
            r_cm_best_idx   <= best_idx;
            r_cm_best_score <= best_score;
            r_cm_match      <= match;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule
